// File: rtl/checksum_accum_pkg.sv
// Shared defaults and FSM state type for the checksum accumulator stage.
package checksum_accum_pkg;

  localparam int unsigned DATA_W_DEF     = 12;
  localparam int unsigned CNT_W_DEF      = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } acc_state_e;

endpackage

// File: rtl/checksum_accum_if.sv
// Term input / result output bundle between checksum stage, accumulator and next stage.
interface checksum_accum_if
  import checksum_accum_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
);

  logic              in_data_vld;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_ready;
  logic              out_vld;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  out_terms;
  logic              frame_active;
  logic              ovf_err;

  modport master (
    output in_data_vld, in_data, in_last, out_ready,
    input  out_vld, out_data, out_terms, frame_active, ovf_err
  );

  modport slave (
    input  in_data_vld, in_data, in_last, out_ready,
    output out_vld, out_data, out_terms, frame_active, ovf_err
  );

endinterface

// File: rtl/checksum_result_fifo.sv
// Small synchronous result FIFO; a push into a full FIFO succeeds only if a pop happens on the same edge.
module checksum_result_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/checksum_accum.sv
// Folds per-byte checksum terms into one ones-complement sum per frame and queues results.
// Optional: define CHECKSUM_ACCUM_INVERT_EN to push ~sum (transmit-ready checksum).
module checksum_accum
  import checksum_accum_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  checksum_accum_if.slave  bus
);

  localparam int unsigned PW = DATA_W + CNT_W;

  acc_state_e        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] fold;
  logic [CNT_W-1:0]  cnt_inc;
  logic              push;
  logic [DATA_W-1:0] res_val;
  logic [CNT_W-1:0]  res_cnt;
  logic [DATA_W-1:0] push_val;
  logic              pop, fifo_full, fifo_empty;
  logic [PW-1:0]     head;

  // End-around carry; a second carry is impossible for two DATA_W-bit operands.
  assign sum     = {1'b0, acc_q} + {1'b0, bus.in_data};
  assign fold    = sum[DATA_W-1:0] + DATA_W'(sum[DATA_W]);
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef CHECKSUM_ACCUM_INVERT_EN
  assign push_val = ~res_val;
`else
  assign push_val = res_val;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    res_val = fold;
    res_cnt = cnt_inc;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_data_vld) begin
          if (bus.in_last) begin
            push    = 1'b1;
            res_val = bus.in_data;
            res_cnt = CNT_W'(1);
          end else begin
            state_d = ST_ACCUM;
            acc_d   = bus.in_data;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_ACCUM: begin
        if (bus.in_data_vld) begin
          if (bus.in_last) begin
            state_d = ST_IDLE;
            push    = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            acc_d = fold;
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A full FIFO still accepts the push when the head leaves on the same edge.
    ovf_d = ovf_q | (push & fifo_full & ~pop);
  end

  assign pop = bus.out_ready & ~fifo_empty;

  checksum_result_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i ({push_val, res_cnt}),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

  assign bus.out_vld      = ~fifo_empty;
  assign bus.out_data     = head[PW-1:CNT_W];
  assign bus.out_terms    = head[CNT_W-1:0];
  assign bus.frame_active = (state_q == ST_ACCUM);
  assign bus.ovf_err      = ovf_q;

endmodule

// File: tb/tb_checksum_accum.sv
// Directed bench for checksum_accum; honours CHECKSUM_ACCUM_INVERT_EN when expecting results.
module tb_checksum_accum;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  checksum_accum_if #(.DATA_W(12), .CNT_W(8)) bus ();

  checksum_accum #(.DATA_W(12), .FIFO_DEPTH(2), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] xr(input logic [11:0] v);
`ifdef CHECKSUM_ACCUM_INVERT_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic send(input logic [11:0] d, input logic l);
    @(negedge clk);
    bus.in_data_vld = 1'b1;
    bus.in_data     = d;
    bus.in_last     = l;
    @(posedge clk);
    #1;
    bus.in_data_vld = 1'b0;
    bus.in_last     = 1'b0;
    bus.in_data     = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.in_data_vld = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.out_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b want=0", bus.out_vld); end
    total++; if (bus.out_data !== 12'h000) begin bad++; $display("FAIL reset_data got=%h want=000", bus.out_data); end
    total++; if (bus.out_terms !== 8'd0) begin bad++; $display("FAIL reset_terms got=%0d want=0", bus.out_terms); end
    total++; if (bus.frame_active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b want=0", bus.frame_active); end
    total++; if (bus.ovf_err !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", bus.ovf_err); end
    reset_n = 1'b1;
  endtask

  task automatic test_basic_sum();
    @(negedge clk) bus.out_ready = 1'b1;
    send(12'h001, 1'b0);
    total++; if (bus.frame_active !== 1'b1) begin bad++; $display("FAIL basic_active got=%b want=1", bus.frame_active); end
    send(12'h002, 1'b0);
    total++; if (bus.out_vld !== 1'b0) begin bad++; $display("FAIL basic_early_vld got=%b want=0", bus.out_vld); end
    send(12'h003, 1'b1);
    total++; if (bus.out_vld !== 1'b1) begin bad++; $display("FAIL basic_vld got=%b want=1", bus.out_vld); end
    total++; if (bus.out_data !== xr(12'h006)) begin bad++; $display("FAIL basic_data got=%h want=%h", bus.out_data, xr(12'h006)); end
    total++; if (bus.out_terms !== 8'd3) begin bad++; $display("FAIL basic_terms got=%0d want=3", bus.out_terms); end
    total++; if (bus.frame_active !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b want=0", bus.frame_active); end
    @(posedge clk) #1;
    total++; if (bus.out_vld !== 1'b0) begin bad++; $display("FAIL basic_popped got=%b want=0", bus.out_vld); end
  endtask

  task automatic test_carry_and_single();
    send(12'hFFF, 1'b0);
    send(12'h002, 1'b1);
    total++; if (bus.out_data !== xr(12'h002)) begin bad++; $display("FAIL carry_data got=%h want=%h", bus.out_data, xr(12'h002)); end
    total++; if (bus.out_terms !== 8'd2) begin bad++; $display("FAIL carry_terms got=%0d want=2", bus.out_terms); end
    @(posedge clk) #1;
    send(12'h0AB, 1'b1);
    total++; if (bus.frame_active !== 1'b0) begin bad++; $display("FAIL single_active got=%b want=0", bus.frame_active); end
    total++; if (bus.out_data !== xr(12'h0AB)) begin bad++; $display("FAIL single_data got=%h want=%h", bus.out_data, xr(12'h0AB)); end
    total++; if (bus.out_terms !== 8'd1) begin bad++; $display("FAIL single_terms got=%0d want=1", bus.out_terms); end
    @(posedge clk) #1;
  endtask

  task automatic test_overflow();
    do_reset();
    send(12'h011, 1'b1);
    send(12'h022, 1'b1);
    total++; if (bus.ovf_err !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b want=0", bus.ovf_err); end
    send(12'h033, 1'b1);
    total++; if (bus.ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", bus.ovf_err); end
    total++; if (bus.out_data !== xr(12'h011)) begin bad++; $display("FAIL ovf_head0 got=%h want=%h", bus.out_data, xr(12'h011)); end
    @(negedge clk) bus.out_ready = 1'b1;
    @(posedge clk) #1;
    total++; if (bus.out_data !== xr(12'h022)) begin bad++; $display("FAIL ovf_head1 got=%h want=%h", bus.out_data, xr(12'h022)); end
    @(posedge clk) #1;
    total++; if (bus.out_vld !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%b want=0", bus.out_vld); end
    total++; if (bus.out_data !== 12'h000) begin bad++; $display("FAIL ovf_empty_data got=%h want=000", bus.out_data); end
    total++; if (bus.ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", bus.ovf_err); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    send(12'h00A, 1'b1);
    send(12'h00B, 1'b1);
    @(negedge clk);
    bus.out_ready   = 1'b1;
    bus.in_data_vld = 1'b1;
    bus.in_data     = 12'h00C;
    bus.in_last     = 1'b1;
    @(posedge clk) #1;
    bus.in_data_vld = 1'b0;
    bus.in_last     = 1'b0;
    bus.out_ready   = 1'b0;
    total++; if (bus.ovf_err !== 1'b0) begin bad++; $display("FAIL fullpp_ovf got=%b want=0", bus.ovf_err); end
    total++; if (bus.out_data !== xr(12'h00B)) begin bad++; $display("FAIL fullpp_head got=%h want=%h", bus.out_data, xr(12'h00B)); end
    @(negedge clk) bus.out_ready = 1'b1;
    @(posedge clk) #1;
    total++; if (bus.out_data !== xr(12'h00C)) begin bad++; $display("FAIL fullpp_second got=%h want=%h", bus.out_data, xr(12'h00C)); end
    total++; if (bus.out_vld !== 1'b1) begin bad++; $display("FAIL fullpp_vld got=%b want=1", bus.out_vld); end
    @(posedge clk) #1;
    total++; if (bus.out_vld !== 1'b0) begin bad++; $display("FAIL fullpp_drained got=%b want=0", bus.out_vld); end
  endtask

  task automatic test_saturate();
    do_reset();
    @(negedge clk) bus.out_ready = 1'b1;
    for (int i = 0; i < 300; i++) send(12'h000, 1'b0);
    total++; if (bus.frame_active !== 1'b1) begin bad++; $display("FAIL sat_active got=%b want=1", bus.frame_active); end
    send(12'h000, 1'b1);
    total++; if (bus.out_terms !== 8'd255) begin bad++; $display("FAIL sat_terms got=%0d want=255", bus.out_terms); end
    total++; if (bus.out_data !== xr(12'h000)) begin bad++; $display("FAIL sat_data got=%h want=%h", bus.out_data, xr(12'h000)); end
    @(posedge clk) #1;
  endtask

  task automatic test_reset_midframe();
    do_reset();
    send(12'h0AB, 1'b1);
    send(12'h100, 1'b0);
    send(12'h200, 1'b0);
    total++; if (bus.out_vld !== 1'b1) begin bad++; $display("FAIL mid_pre_vld got=%b want=1", bus.out_vld); end
    @(negedge clk) #2;
    reset_n = 1'b0;
    #1;
    total++; if (bus.out_vld !== 1'b0) begin bad++; $display("FAIL mid_vld got=%b want=0", bus.out_vld); end
    total++; if (bus.out_data !== 12'h000) begin bad++; $display("FAIL mid_data got=%h want=000", bus.out_data); end
    total++; if (bus.out_terms !== 8'd0) begin bad++; $display("FAIL mid_terms got=%0d want=0", bus.out_terms); end
    total++; if (bus.frame_active !== 1'b0) begin bad++; $display("FAIL mid_active got=%b want=0", bus.frame_active); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    send(12'h005, 1'b1);
    total++; if (bus.out_data !== xr(12'h005)) begin bad++; $display("FAIL mid_after_data got=%h want=%h", bus.out_data, xr(12'h005)); end
    total++; if (bus.out_terms !== 8'd1) begin bad++; $display("FAIL mid_after_terms got=%0d want=1", bus.out_terms); end
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_carry_and_single();
    test_overflow();
    test_full_push_pop();
    test_saturate();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/checksum_accum.md
Name: checksum_accum

Overview:
- Downstream stage of the checksum block. Consumes its 12-bit per-byte terms (out_data/out_data_vld) and folds them into one 12-bit ones-complement sum per frame.
- Finished frame results go into a small result FIFO and are offered to the next stage with a valid/ready handshake.
- Also reports the frame term count and a sticky overflow error.

Parameters:
- DATA_W, 12, width of input terms and of the accumulated result
- FIFO_DEPTH, 2, result FIFO entries (power of two, >=2)
- CNT_W, 8, width of the per-frame term counter (saturating)

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_data_vld  in  1  term valid, driven by checksum out_data_vld; always accepted, no backpressure
- in_data  in  DATA_W  term value
- in_last  in  1  qualifies in_data_vld: this term closes the frame
- out_ready  in  1  downstream accepts head result
- out_vld  out  1  FIFO non-empty
- out_data  out  DATA_W  head result; 0 when empty
- out_terms  out  CNT_W  term count of head result; 0 when empty
- frame_active  out  1  high while a frame is open (state ACCUM)
- ovf_err  out  1  sticky: a completed result was dropped because the FIFO was full

Behaviour:
- Reset (async assert, sync release): acc=0, cnt=0, state IDLE, FIFO empty, ovf_err=0. All outputs are 0.
- Fold rule: s = acc + in_data (DATA_W+1 bits); fold = s[DATA_W-1:0] + s[DATA_W]. A second carry cannot occur (0xFFF+0xFFF -> 0xFFF).
- FSM:
  - IDLE: vld&!last -> ACCUM, acc<=in_data, cnt<=1.
  - IDLE: vld&last -> stays IDLE; push result {in_data, 1}.
  - ACCUM: vld&!last -> acc<=fold, cnt<=sat(cnt+1).
  - ACCUM: vld&last -> IDLE; push {fold, sat(cnt+1)}; acc<=0, cnt<=0.
  - No vld -> hold.
- cnt saturates at 2^CNT_W-1; it never wraps.
- Latency: a push on edge N shows out_vld=1 and its data in the cycle after edge N. No combinational in->out path.
- Pop: happens on an edge with out_vld&out_ready. The next entry, or empty/0, appears after that edge.
- Full FIFO:
  - Push without pop -> the result is discarded, ovf_err<=1, and the FSM still returns to IDLE.
  - Push with pop in the same edge -> both succeed; occupancy is unchanged.
- Empty FIFO: out_ready is ignored.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter is log2(FIFO_DEPTH)+1 bits.
- ovf_err clears only on reset.
- Reset mid-frame: the partial frame and all FIFO contents are lost, with no output.

Optional Feature:
- Macro: CHECKSUM_ACCUM_INVERT_EN.
- Defined: each pushed result is bitwise-inverted (~fold) before entering the FIFO, giving a transmit-ready ones-complement checksum.
- Undefined: the raw folded sum is pushed.
- acc, cnt and all timing are identical in both builds.

Decomposition:
- Shared package: DATA_W/CNT_W defaults and FSM state typedef (IDLE, ACCUM).
- Sub-module: checksum_result_fifo (sync FIFO, push/pop, full/empty, width DATA_W+CNT_W). The parent holds the FSM, accumulator and fold.

Test Plan:
- Frame 0x001, 0x002, 0x003 (last on third), out_ready=1 -> one cycle after the last edge: out_vld=1, out_data=0x006, out_terms=3. With INVERT_EN: out_data=0xFF9.
- Frame 0xFFF, 0x002 last -> out_data=0x002 (end-around carry), out_terms=2. Single-term frame 0x0AB with last -> 0x0AB, terms=1, and frame_active stays 0.
- out_ready=0; three single-term frames 0x011, 0x022, 0x033 -> FIFO holds 0x011, 0x022; ovf_err=1. Raising out_ready then yields 0x011 then 0x022, then out_vld=0.
- FIFO full plus a last term on the same edge as out_ready=1 -> head is popped and the new result is stored; ovf_err stays 0; occupancy stays 2.
- 300 non-last terms of 0x000 then last -> out_terms=255 (saturated), out_data=0x000.
- Assert reset_n=0 mid-frame after 0x100, 0x200 -> all outputs 0 immediately. After release, frame 0x005 last -> out_data=0x005.
